ps2_scan_receiver: RTL
======================

PS2_SCAN_RECEIVER -- requirements
Module: ps2_scan_receiver

Interface
REQ-001 Parameter TIMEOUT_TICKS, default 2000, CLK_en ticks allowed between PS/2 falling edges before the frame is aborted.
REQ-002 CLK  in  1  system clock; one clock domain only.
REQ-003 RESET  in  1  reset, synchronous to CLK, active-high.
REQ-004 CLK_en  in  1  1 MHz sample enable (IO_en); all state except the synchronizers advances only when CLK_en=1.
REQ-005 PS2_CLK  in  1  asynchronous PS/2 clock from the keyboard connector.
REQ-006 PS2_DATA  in  1  asynchronous PS/2 data from the keyboard connector.
REQ-007 ACK  in  1  consumer (Keyboard matrix) accepts the current code; sampled on any CLK.
REQ-008 CODE  out  8  scan code, set-2 byte with prefixes removed.
REQ-009 EXTENDED  out  1  CODE was preceded by E0.
REQ-010 BREAK  out  1  CODE was preceded by F0 (key release).
REQ-011 VALID  out  1  CODE/EXTENDED/BREAK hold a code not yet acknowledged.
REQ-012 FRAME_ERROR  out  1  one-CLK pulse on a start, parity, stop or timeout failure.
REQ-013 OVERRUN  out  1  sticky; a code was dropped because VALID was still high.

Function
REQ-014 PS2_CLK and PS2_DATA shall each pass through a 2-flop synchronizer clocked every CLK.
REQ-015 A falling edge is a CLK_en cycle whose synchronized PS2_CLK is 0 and whose value at the previous CLK_en was 1; data is sampled on that same cycle.
REQ-016 Frame states: IDLE, DATA, PARITY, STOP; a 3-bit counter indexes DATA bits, LSB first.
REQ-017 IDLE: an edge with data=0 enters DATA (counter=0); an edge with data=1 is ignored.
REQ-018 DATA: shift the sample in at each edge; after bit 7 go to PARITY.
REQ-019 PARITY: store the sample and go to STOP; odd parity is required, i.e. the XOR of the 8 data bits and the parity bit shall equal 1.
REQ-020 STOP: sample=1 with good parity gives a valid byte; otherwise pulse FRAME_ERROR; in either case return to IDLE.
REQ-021 Timeout counter: cleared on each edge; increments on CLK_en while the state is not IDLE; on reaching TIMEOUT_TICKS go to IDLE and pulse FRAME_ERROR.
REQ-022 Valid byte F0: set break_pending and emit nothing. Valid byte E0: set ext_pending and emit nothing.
REQ-023 Any other valid byte (including E1, AA, FA, EE) is emitted with EXTENDED=ext_pending and BREAK=break_pending, after which both pending flags are cleared.
REQ-024 Emission: CODE, EXTENDED, BREAK and VALID update on the CLK edge that ends the CLK_en cycle sampling the stop bit; latency is 1 CLK from that sample.
REQ-025 CODE, EXTENDED and BREAK shall remain stable while VALID=1.
REQ-026 VALID falls on the CLK after ACK=1; ACK while VALID=0 has no effect.
REQ-027 Emission while VALID=1 with no same-cycle ACK: the new code is dropped, OVERRUN is set, and the held code is unchanged.
REQ-028 Emission in the same cycle as ACK: the new code is loaded and VALID stays 1; this is not an overrun.
REQ-029 Any FRAME_ERROR shall also clear ext_pending and break_pending.
REQ-030 OVERRUN clears only on RESET.

Reset
REQ-031 RESET=1 at a CLK edge forces: state=IDLE, counters=0, pending flags=0, CODE=00, EXTENDED=0, BREAK=0, VALID=0, FRAME_ERROR=0, OVERRUN=0, synchronizers=1.
REQ-032 RESET mid-frame discards the partial byte with no FRAME_ERROR; reception resumes at the next start bit after RESET falls.
REQ-033 RESET shall take effect regardless of CLK_en.

Structure
REQ-034 Shared package ps2_pkg shall hold the frame-state encoding, the constants PS2_BREAK=F0 and PS2_EXT=E0, and the TIMEOUT_TICKS default.
REQ-035 Sub-module ps2_frame_rx shall contain the synchronizer, edge detection, frame FSM and timeout; it outputs byte, byte_valid and frame_error.
REQ-036 The top level shall contain the prefix decoder and the VALID/ACK holding register.

Verification
REQ-037 Frame 1C with good parity, ACK tied low -> VALID=1, CODE=1C, EXTENDED=0, BREAK=0; VALID stays 1 until ACK is pulsed.
REQ-038 Frames E0,F0,75 -> exactly one emission: CODE=75, EXTENDED=1, BREAK=1; the next frame 1C emits with EXTENDED=0, BREAK=0.
REQ-039 Frame 1C with the parity bit flipped -> one FRAME_ERROR pulse, no VALID; a prior F0 is forgotten.
REQ-040 Start bit plus 4 data bits, then PS2_CLK held high for 2000 ticks -> FRAME_ERROR pulse and IDLE; the next full frame 32 is emitted correctly.
REQ-041 Frames 1C then 32 without ACK -> CODE stays 1C and OVERRUN=1; the same sequence with ACK coincident with the second emission -> CODE=32, OVERRUN=0.
REQ-042 RESET asserted after bit 5 of a frame -> all outputs 0 with no FRAME_ERROR; a following frame 29 is emitted correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code receiver: frame states, prefix bytes,
// default inter-edge timeout and the odd-parity check.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam int TIMEOUT_TICKS_DEFAULT = 2000;

  // Data bits plus the parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: input synchronizers, falling-edge detection on
// the CLK_en grid, 11-bit frame FSM and an inter-edge timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEFAULT
) (
  input  logic       clk_i,
  input  logic       srst_i,
  input  logic       clk_en_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_error_o
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  logic [1:0]   clk_sync_q;
  logic [1:0]   data_sync_q;
  logic         clk_prev_q;
  frame_state_e state_q, state_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]   shift_q, shift_d;
  logic         parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic         frame_error_q, frame_error_d;

  logic ps2_clk_s;
  logic sample;
  logic fall;

  assign ps2_clk_s = clk_sync_q[1];
  assign sample    = data_sync_q[1];
  assign fall      = clk_en_i & clk_prev_q & ~ps2_clk_s;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      clk_sync_q    <= 2'b11;
      data_sync_q   <= 2'b11;
      clk_prev_q    <= 1'b1;
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      tmo_q         <= '0;
      frame_error_q <= 1'b0;
    end else begin
      clk_sync_q    <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q   <= {data_sync_q[0], ps2_data_i};
      if (clk_en_i) begin
        clk_prev_q <= ps2_clk_s;
      end
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      tmo_q         <= tmo_d;
      frame_error_q <= frame_error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    tmo_d         = tmo_q;
    frame_error_d = 1'b0;
    byte_valid_o  = 1'b0;

    if (fall) begin
      tmo_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          if (!sample) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {sample, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          parity_d = sample;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          // The byte is presented combinationally so the holding register loads on this edge.
          if (sample && odd_parity_ok(shift_q, parity_q)) begin
            byte_valid_o = 1'b1;
          end else begin
            frame_error_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (clk_en_i && (state_q != ST_IDLE)) begin
      if (tmo_q == TW'(TIMEOUT_TICKS - 1)) begin
        state_d       = ST_IDLE;
        tmo_d         = '0;
        frame_error_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  assign byte_o        = shift_q;
  assign frame_error_o = frame_error_q;

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard scan-code receiver: strips E0/F0 prefixes from received set-2 bytes
// and holds each code until the consumer acknowledges it.
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEFAULT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_en,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  input  logic       ACK,
  output logic [7:0] CODE,
  output logic       EXTENDED,
  output logic       BREAK,
  output logic       VALID,
  output logic       FRAME_ERROR,
  output logic       OVERRUN
);

  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       rx_frame_error;

  ps2_frame_rx #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_rx (
    .clk_i        (CLK),
    .srst_i       (RESET),
    .clk_en_i     (CLK_en),
    .ps2_clk_i    (PS2_CLK),
    .ps2_data_i   (PS2_DATA),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_byte_valid),
    .frame_error_o(rx_frame_error)
  );

  logic [7:0] code_q, code_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;
  logic       ext_pend_q, ext_pend_d;
  logic       brk_pend_q, brk_pend_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      code_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
    end else begin
      code_q     <= code_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
    end
  end

  always_comb begin
    code_d     = code_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;

    if (ACK && valid_q) begin
      valid_d = 1'b0;
    end

    if (rx_frame_error) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (rx_byte_valid) begin
      if (rx_byte == PS2_BREAK) begin
        brk_pend_d = 1'b1;
      end else if (rx_byte == PS2_EXT) begin
        ext_pend_d = 1'b1;
      end else begin
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
        // A same-cycle ACK frees the holder, so the new code replaces the old one.
        if (!valid_q || ACK) begin
          code_d  = rx_byte;
          ext_d   = ext_pend_q;
          brk_d   = brk_pend_q;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end
  end

  assign CODE        = code_q;
  assign EXTENDED    = ext_q;
  assign BREAK       = brk_q;
  assign VALID       = valid_q;
  assign FRAME_ERROR = rx_frame_error;
  assign OVERRUN     = overrun_q;

endmodule
